// File: rtl/multiplexador_arbitrado.sv
// multiplexador_arbitrado
// Two-to-one merge of producer words onto one registered output channel.
// Arbitration is per word; the output register holds its word until the
// consumer accepts it, and a new word may load in the same cycle the old one
// leaves (1 word/clk). Saturating per-source accept counters are provided.
//
// Build option: define MUX_ARB_ROUND_ROBIN_EN for round-robin arbitration
// (the source other than the last granted one wins a tie). Without it, in1
// has fixed priority when both producers are valid.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   in1_valid/data/ready producer 1 handshake (ready = accepted this cycle)
//   in2_valid/data/ready producer 2 handshake
//   out_valid/data/src   pending merged word, src 0 = in1, 1 = in2
//   out_ready            consumer takes the pending word this cycle
//   cnt1, cnt2           accepted-word counters, saturate at all-ones
module multiplexador_arbitrado #(
  parameter int unsigned data_bits  = 32,
  parameter int unsigned count_bits = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in1_valid,
  input  logic [data_bits-1:0]  in1_data,
  output logic                  in1_ready,
  input  logic                  in2_valid,
  input  logic [data_bits-1:0]  in2_data,
  output logic                  in2_ready,
  output logic                  out_valid,
  output logic [data_bits-1:0]  out_data,
  output logic                  out_src,
  input  logic                  out_ready,
  output logic [count_bits-1:0] cnt1,
  output logic [count_bits-1:0] cnt2
);

  typedef enum logic {VAZIO, CHEIO} state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   grant1, grant2;
  logic   can_load;
  logic   acc1, acc2;

  // Arbitration depends only on valids (never on data) so ready has no
  // combinational path from in*_data.
  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (in1_valid && in2_valid) begin
`ifdef MUX_ARB_ROUND_ROBIN_EN
      grant1 = last_grant;
      grant2 = ~last_grant;
`else
      // last_grant is still tracked but plays no part in fixed priority.
      grant1 = 1'b1;
      grant2 = last_grant & 1'b0;
`endif
    end else begin
      grant1 = in1_valid;
      grant2 = in2_valid;
    end
  end

  assign can_load  = (state == VAZIO) || out_ready;
  assign in1_ready = ~reset & can_load & grant1;
  assign in2_ready = ~reset & can_load & grant2;
  assign acc1      = in1_valid & in1_ready;
  assign acc2      = in2_valid & in2_ready;
  assign out_valid = (state == CHEIO);

  always_comb begin
    state_next = state;
    case (state)
      VAZIO: if (in1_valid || in2_valid) state_next = CHEIO;
      CHEIO: if (out_ready && !(acc1 || acc2)) state_next = VAZIO;
      default: state_next = VAZIO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= VAZIO;
      out_data   <= '0;
      out_src    <= 1'b0;
      cnt1       <= '0;
      cnt2       <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (acc1) begin
        out_data   <= in1_data;
        out_src    <= 1'b0;
        last_grant <= 1'b0;
        if (cnt1 != '1) cnt1 <= cnt1 + 1'b1;
      end else if (acc2) begin
        out_data   <= in2_data;
        out_src    <= 1'b1;
        last_grant <= 1'b1;
        if (cnt2 != '1) cnt2 <= cnt2 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multiplexador_arbitrado.sv
// Bench for multiplexador_arbitrado: directed vectors with literal expectations
// plus a transaction-level model compared every cycle.
module tb_multiplexador_arbitrado;
  localparam int DB = 32;
  localparam int CB = 4;
  localparam int CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in1_valid = 1'b0, in2_valid = 1'b0, out_ready = 1'b0;
  logic [DB-1:0] in1_data = '0, in2_data = '0;
  logic          in1_ready, in2_ready, out_valid, out_src;
  logic [DB-1:0] out_data;
  logic [CB-1:0] cnt1, cnt2;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  multiplexador_arbitrado #(.data_bits(DB), .count_bits(CB)) dut (
    .clk(clk), .reset(reset),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_ready(in2_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: one pending-word slot, who-was-served-last, and two counters.
  bit          m_valid;
  logic [DB-1:0] m_data;
  bit          m_src;
  int          m_cnt1, m_cnt2;
  int          m_last; // 1 or 2: source served most recently

  // Inputs change just after posedge, so at negedge they equal what the
  // next posedge will sample.
  always @(negedge clk) begin
    int winner;
    bit room;
    room = !m_valid || out_ready;
    winner = 0;
    if (in1_valid && in2_valid) begin
`ifdef MUX_ARB_ROUND_ROBIN_EN
      winner = (m_last == 1) ? 2 : 1;
`else
      winner = 1;
`endif
    end else if (in1_valid) winner = 1;
    else if (in2_valid) winner = 2;
    if (!room || reset) winner = 0;

    if (chk_en) begin
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_data",  64'(out_data),  64'(m_data));
      check("out_src",   64'(out_src),   64'(m_src));
      check("cnt1",      64'(cnt1),      64'(m_cnt1));
      check("cnt2",      64'(cnt2),      64'(m_cnt2));
      check("in1_ready", 64'(in1_ready), 64'(winner == 1));
      check("in2_ready", 64'(in2_ready), 64'(winner == 2));
    end

    if (reset) begin
      m_valid = 0; m_data = '0; m_src = 0; m_cnt1 = 0; m_cnt2 = 0; m_last = 2;
    end else if (winner != 0) begin
      m_valid = 1;
      m_data  = (winner == 1) ? in1_data : in2_data;
      m_src   = (winner == 2);
      m_last  = winner;
      if (winner == 1 && m_cnt1 < CMAX) m_cnt1++;
      if (winner == 2 && m_cnt2 < CMAX) m_cnt2++;
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DB-1:0] seq [4];

  initial begin
    // T1: reset with inputs active
    reset = 1; in1_valid = 1; in2_valid = 1; in1_data = 32'h1; in2_data = 32'h2; out_ready = 1;
    step(); step();
    #1;
    check("t1_out_valid", 64'(out_valid), 64'd0);
    check("t1_out_data",  64'(out_data),  64'd0);
    check("t1_cnt1",      64'(cnt1),      64'd0);
    check("t1_cnt2",      64'(cnt2),      64'd0);
    check("t1_in1_ready", 64'(in1_ready), 64'd0);
    check("t1_in2_ready", 64'(in2_ready), 64'd0);
    chk_en = 1;
    in1_valid = 0; in2_valid = 0;
    step();
    reset = 0;

    // T2: single source
    in1_valid = 1; in1_data = 32'hA5A5_0001; out_ready = 1;
    #1 check("t2_in1_ready", 64'(in1_ready), 64'd1);
    step();
    in1_valid = 0;
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_out_data",  64'(out_data),  64'hA5A5_0001);
    check("t2_out_src",   64'(out_src),   64'd0);
    check("t2_cnt1",      64'(cnt1),      64'd1);
    step();

    // T3: contention from a fresh reset
    reset = 1; step(); reset = 0;
    in1_valid = 1; in2_valid = 1; in1_data = 32'h11; in2_data = 32'h22; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_no_bubble", 64'(out_valid), 64'd1);
      seq[i] = out_data;
    end
    in1_valid = 0; in2_valid = 0;
`ifdef MUX_ARB_ROUND_ROBIN_EN
    check("t3_w0", 64'(seq[0]), 64'h11);
    check("t3_w1", 64'(seq[1]), 64'h22);
    check("t3_w2", 64'(seq[2]), 64'h11);
    check("t3_w3", 64'(seq[3]), 64'h22);
    check("t3_cnt1", 64'(cnt1), 64'd2);
    check("t3_cnt2", 64'(cnt2), 64'd2);
`else
    for (int i = 0; i < 4; i++) check("t3_w", 64'(seq[i]), 64'h11);
    check("t3_cnt1", 64'(cnt1), 64'd4);
    check("t3_cnt2", 64'(cnt2), 64'd0);
`endif
    step();

    // T4: backpressure
    in2_valid = 1; in2_data = 32'hDEAD_BEEF; out_ready = 1;
    step();
    in2_valid = 0; in1_valid = 1; in1_data = 32'h0000_1234; out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1 check("t4_in1_ready_low", 64'(in1_ready), 64'd0);
      step();
      check("t4_hold_data", 64'(out_data), 64'hDEAD_BEEF);
      check("t4_hold_src",  64'(out_src),  64'd1);
    end
    out_ready = 1;
    #1 check("t4_in1_ready_high", 64'(in1_ready), 64'd1);
    step();
    in1_valid = 0;
    check("t4_next_data", 64'(out_data), 64'h0000_1234);
    check("t4_next_src",  64'(out_src),  64'd0);
    step();

    // T5: saturation with count_bits = 4
    reset = 1; step(); reset = 0;
    in1_valid = 1; out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      in1_data = 32'h100 + 32'(i);
      step();
    end
    in1_valid = 0;
    check("t5_cnt1_sat", 64'(cnt1), 64'd15);
    check("t5_cnt2",     64'(cnt2), 64'd0);
    check("t5_last",     64'(out_data), 64'h113);

    // T6: reset while a word is pending
    in1_valid = 1; in1_data = 32'h66; out_ready = 0;
    step();
    in1_valid = 0;
    check("t6_pending", 64'(out_valid), 64'd1);
    reset = 1; step(); reset = 0;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_cnt1",      64'(cnt1),      64'd0);
    in1_valid = 1; in2_valid = 1; in1_data = 32'h77; in2_data = 32'h88; out_ready = 1;
    #1;
    check("t6_grant1", 64'(in1_ready), 64'd1);
    check("t6_grant2", 64'(in2_ready), 64'd0);
    step();
    in1_valid = 0; in2_valid = 0;
    check("t6_first_word", 64'(out_data), 64'h77);
    step(); step();

    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
